// File: rtl/gelato_wb_arbiter_if.sv
// Writeback bus between the execution units, the arbiter and the register file write port.
// slave = arbiter side, master = execution units plus register file side.
interface gelato_wb_arbiter_if #(
  parameter int NUM_SRC     = 3,
  parameter int NUM_THREADS = 32,
  parameter int DATA_W      = 32,
  parameter int WARP_ID_W   = 5,
  parameter int REG_ADDR_W  = 5
) ();
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]                    src_valid;
  logic [NUM_SRC-1:0]                    src_ready;
  logic [NUM_SRC*WARP_ID_W-1:0]          src_warp;
  logic [NUM_SRC*REG_ADDR_W-1:0]         src_rd;
  logic [NUM_SRC*NUM_THREADS-1:0]        src_mask;
  logic [NUM_SRC*NUM_THREADS*DATA_W-1:0] src_data;

  logic                                  wb_valid;
  logic                                  wb_ready;
  logic [WARP_ID_W-1:0]                  wb_warp;
  logic [REG_ADDR_W-1:0]                 wb_rd;
  logic [NUM_THREADS-1:0]                wb_mask;
  logic [NUM_THREADS*DATA_W-1:0]         wb_data;
  logic [SRC_W-1:0]                      wb_src;

  // Round-robin pointer, visible for debug and checkers.
  logic [SRC_W-1:0]                      dbg_last_grant;

  modport slave (
    input  src_valid, src_warp, src_rd, src_mask, src_data, wb_ready,
    output src_ready, wb_valid, wb_warp, wb_rd, wb_mask, wb_data, wb_src, dbg_last_grant
  );

  modport master (
    output src_valid, src_warp, src_rd, src_mask, src_data, wb_ready,
    input  src_ready, wb_valid, wb_warp, wb_rd, wb_mask, wb_data, wb_src, dbg_last_grant
  );
endinterface

// File: rtl/gelato_wb_arbiter.sv
// Round-robin arbiter sharing the register-file writeback port, with one registered output stage.
// Optional starvation aging is enabled by defining GELATO_WB_AGING_EN.
module gelato_wb_arbiter #(
  parameter int NUM_SRC     = 3,
  parameter int NUM_THREADS = 32,
  parameter int DATA_W      = 32,
  parameter int WARP_ID_W   = 5,
  parameter int REG_ADDR_W  = 5,
  parameter int AGE_LIMIT   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  gelato_wb_arbiter_if.slave  bus
);
  localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LANE_W = NUM_THREADS * DATA_W;

  // Handshake: a transfer happens on a rising edge where valid && ready (and rdy) are high.
  // Sources hold valid and payload until ready; ready never depends on anything but the
  // output stage being free and the arbitration result, so it is at most one-hot.

  logic [SRC_W-1:0]      last_grant;
  logic [SRC_W-1:0]      rr_idx;
  logic                  rr_found;
  logic [SRC_W-1:0]      grant_idx;
  logic                  load_en;
  logic                  handshake;
  logic [NUM_SRC-1:0]    src_ready_c;

  logic                  wb_valid_q;
  logic [WARP_ID_W-1:0]  wb_warp_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;
  logic [NUM_THREADS-1:0] wb_mask_q;
  logic [LANE_W-1:0]     wb_data_q;
  logic [SRC_W-1:0]      wb_src_q;

  assign load_en = rdy && (!wb_valid_q || bus.wb_ready);

  // Search last_grant+1, +2, ... wrapping past NUM_SRC-1 back to 0.
  always_comb begin : rr_search
    logic [SRC_W:0] pos;
    rr_found = 1'b0;
    rr_idx   = '0;
    pos      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      pos = {1'b0, last_grant} + (SRC_W+1)'(k);
      if (pos >= (SRC_W+1)'(NUM_SRC)) begin
        pos = pos - (SRC_W+1)'(NUM_SRC);
      end
      if (!rr_found && bus.src_valid[pos[SRC_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = pos[SRC_W-1:0];
      end
    end
  end

`ifdef GELATO_WB_AGING_EN
  localparam int AGE_W = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;

  logic [AGE_W-1:0]  age_q [NUM_SRC];
  logic              aged_found;
  logic [SRC_W-1:0]  aged_idx;

  // Lowest-index aged requester overrides the round-robin pick.
  always_comb begin
    aged_found = 1'b0;
    aged_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.src_valid[i] && (age_q[i] >= AGE_W'(AGE_LIMIT))) begin
        aged_found = 1'b1;
        aged_idx   = SRC_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        age_q[i] <= '0;
      end
    end else if (rdy) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!bus.src_valid[i] || src_ready_c[i]) begin
          age_q[i] <= '0;
        end else if (age_q[i] < AGE_W'(AGE_LIMIT)) begin
          age_q[i] <= age_q[i] + AGE_W'(1);
        end
      end
    end
  end

  assign grant_idx = aged_found ? aged_idx : rr_idx;
`else
  assign grant_idx = rr_idx;
`endif

  // Ready is also held low while reset is asserted so no source sees a phantom accept.
  always_comb begin
    src_ready_c = '0;
    if (rst_n && load_en && rr_found) begin
      src_ready_c[grant_idx] = 1'b1;
    end
  end

  assign handshake = |(src_ready_c & bus.src_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_warp_q  <= '0;
      wb_rd_q    <= '0;
      wb_mask_q  <= '0;
      wb_data_q  <= '0;
      wb_src_q   <= '0;
      last_grant <= SRC_W'(NUM_SRC - 1);
    end else if (load_en) begin
      wb_valid_q <= handshake;
      if (handshake) begin
        wb_warp_q  <= bus.src_warp[grant_idx*WARP_ID_W +: WARP_ID_W];
        wb_rd_q    <= bus.src_rd[grant_idx*REG_ADDR_W +: REG_ADDR_W];
        wb_mask_q  <= bus.src_mask[grant_idx*NUM_THREADS +: NUM_THREADS];
        wb_data_q  <= bus.src_data[grant_idx*LANE_W +: LANE_W];
        wb_src_q   <= grant_idx;
        last_grant <= grant_idx;
      end
    end
  end

  assign bus.src_ready      = src_ready_c;
  assign bus.wb_valid       = wb_valid_q;
  assign bus.wb_warp        = wb_warp_q;
  assign bus.wb_rd          = wb_rd_q;
  assign bus.wb_mask        = wb_mask_q;
  assign bus.wb_data        = wb_data_q;
  assign bus.wb_src         = wb_src_q;
  assign bus.dbg_last_grant = last_grant;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(src_ready_c));

  a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
    ((src_ready_c & ~bus.src_valid) == '0));

  // A stalled or frozen output must not move.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (!rdy || (wb_valid_q && !bus.wb_ready)) |=>
      $stable({wb_valid_q, wb_src_q, wb_warp_q, wb_rd_q, wb_mask_q, wb_data_q}));
endmodule

// File: tb/tb_gelato_wb_arbiter.sv
// Randomized bench for gelato_wb_arbiter: a reference model predicts grants and
// pushes expected writebacks into a queue that an independent monitor drains.
module tb_gelato_wb_arbiter;
  localparam int N         = 3;
  localparam int NT        = 32;
  localparam int DW        = 32;
  localparam int WW        = 5;
  localparam int RW        = 5;
  localparam int AGE_LIMIT = 2;
  localparam int SRC_W     = 2;
  localparam int LW        = NT * DW;
  localparam int IT_W      = WW + RW + NT + LW;
  localparam int EXP_W     = SRC_W + IT_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b0;

  always #5 clk = ~clk;

  gelato_wb_arbiter_if #(.NUM_SRC(N), .NUM_THREADS(NT), .DATA_W(DW),
                         .WARP_ID_W(WW), .REG_ADDR_W(RW)) bus ();

  gelato_wb_arbiter #(.NUM_SRC(N), .NUM_THREADS(NT), .DATA_W(DW), .WARP_ID_W(WW),
                      .REG_ADDR_W(RW), .AGE_LIMIT(AGE_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus)
  );

  // Item layout: {warp, rd, mask, data}
  logic [IT_W-1:0]  src_q [N][$];
  logic [N-1:0]     cur_valid;
  logic [EXP_W-1:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  int m_last;
  bit m_wbv;
  int m_age [N];
  int p_req [N];
  int p_wbr;
  int p_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [IT_W-1:0] rand_item();
    logic [IT_W-1:0] it;
    for (int i = 0; i < IT_W; i++) it[i] = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 9) == 0) it[LW +: NT] = '0;
    return it;
  endfunction

  function automatic logic [IT_W-1:0] make_item(input int warp, input int rd,
                                                  input logic [NT-1:0] mask);
    logic [IT_W-1:0] it;
    it = rand_item();
    it[LW +: NT]           = mask;
    it[LW + NT +: RW]      = RW'(rd);
    it[LW + NT + RW +: WW] = WW'(warp);
    return it;
  endfunction

  task automatic model_reset();
    m_last = N - 1;
    m_wbv  = 1'b0;
    for (int i = 0; i < N; i++) m_age[i] = 0;
  endtask

  task automatic refill();
    for (int i = 0; i < N; i++)
      if (src_q[i].size() < 2) src_q[i].push_back(rand_item());
  endtask

  // Called just after a rising edge: sources keep an offered request until it is taken.
  task automatic drive();
    logic [IT_W-1:0] it;
    for (int i = 0; i < N; i++) begin
      if (!cur_valid[i] && src_q[i].size() > 0 && $urandom_range(0, 99) < p_req[i])
        cur_valid[i] = 1'b1;
      it = cur_valid[i] ? src_q[i][0] : '0;
      bus.src_data[i*LW +: LW] = it[0 +: LW];
      bus.src_mask[i*NT +: NT] = it[LW +: NT];
      bus.src_rd[i*RW +: RW]   = it[LW + NT +: RW];
      bus.src_warp[i*WW +: WW] = it[LW + NT + RW +: WW];
    end
    bus.src_valid = cur_valid;
    rdy           = ($urandom_range(0, 99) < p_rdy);
    bus.wb_ready  = ($urandom_range(0, 99) < p_wbr);
  endtask

  // Called between edges: predict this cycle's accept and advance the model one clock.
  task automatic model_step();
    bit load, found;
    int g, idx;
    logic [N-1:0] exp_ready;
    load  = rdy && (!m_wbv || bus.wb_ready);
    found = 1'b0;
    g     = 0;
`ifdef GELATO_WB_AGING_EN
    for (int i = 0; i < N; i++)
      if (!found && cur_valid[i] && m_age[i] >= AGE_LIMIT) begin found = 1'b1; g = i; end
`endif
    for (int k = 1; k <= N; k++) begin
      idx = (m_last + k) % N;
      if (!found && cur_valid[idx]) begin found = 1'b1; g = idx; end
    end
    exp_ready = '0;
    if (load && found) exp_ready[g] = 1'b1;
    check("src_ready", 32'(bus.src_ready), 32'(exp_ready));
    check("wb_valid", 32'(bus.wb_valid), 32'(m_wbv));
    if (rdy) begin
`ifdef GELATO_WB_AGING_EN
      for (int i = 0; i < N; i++) begin
        if (!cur_valid[i] || exp_ready[i]) m_age[i] = 0;
        else if (m_age[i] < AGE_LIMIT) m_age[i]++;
      end
`endif
      if (load) begin
        m_wbv = found;
        if (found) begin
          exp_q.push_back({SRC_W'(g), src_q[g].pop_front()});
          cur_valid[g] = 1'b0;
          m_last = g;
        end
      end
    end
  endtask

  task automatic run_cycles(input int n, input bit do_refill);
    repeat (n) begin
      if (do_refill) refill();
      drive();
      @(negedge clk);
      #1;
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_probs(input int r0, input int r1, input int r2, input int wbr, input int rd);
    p_req[0] = r0;
    p_req[1] = r1;
    p_req[2] = r2;
    p_wbr    = wbr;
    p_rdy    = rd;
  endtask

  task automatic mid_reset();
    int tries;
    tries = 0;
    while (!m_wbv && tries < 50) begin
      run_cycles(1, 1'b1);
      tries++;
    end
    check("reset_found_busy_output", 32'(m_wbv), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("async_reset_src_ready", 32'(bus.src_ready), 32'd0);
    check("async_reset_last_grant", 32'(bus.dbg_last_grant), 32'(N - 1));
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every consumed writeback must match the oldest expected one.
  initial begin
    logic [EXP_W-1:0] e, a;
    forever begin
      @(negedge clk);
      if (rst_n && rdy && bus.wb_valid && bus.wb_ready) begin
        n_vec++;
        a = {bus.wb_src, bus.wb_warp, bus.wb_rd, bus.wb_mask, bus.wb_data};
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL wb_unexpected: got src=%0d warp=%0d rd=%0d with nothing expected at %0t",
                   bus.wb_src, bus.wb_warp, bus.wb_rd, $time);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_err++;
            $display("FAIL wb_payload: got src=%0d warp=%0d rd=%0d mask=%h data_lo=%h expected src=%0d warp=%0d rd=%0d mask=%h data_lo=%h",
                     a[IT_W +: SRC_W], a[LW+NT+RW +: WW], a[LW+NT +: RW], a[LW +: NT], a[0 +: 32],
                     e[IT_W +: SRC_W], e[LW+NT+RW +: WW], e[LW+NT +: RW], e[LW +: NT], e[0 +: 32]);
          end
        end
      end
    end
  end

  initial begin
    int budget;
    cur_valid     = '0;
    bus.src_valid = '0;
    bus.src_warp  = '0;
    bus.src_rd    = '0;
    bus.src_mask  = '0;
    bus.src_data  = '0;
    bus.wb_ready  = 1'b0;
    model_reset();

    // Reset state with every source requesting.
    set_probs(100, 100, 100, 100, 100);
    refill();
    repeat (2) @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check("reset_src_ready", 32'(bus.src_ready), 32'd0);
    check("reset_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("reset_wb_src", 32'(bus.wb_src), 32'd0);
    check("reset_wb_fields", 32'({bus.wb_warp, bus.wb_rd}), 32'd0);
    check("reset_wb_mask", 32'(bus.wb_mask), 32'd0);
    check("reset_last_grant", 32'(bus.dbg_last_grant), 32'(N - 1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All sources busy, register file always ready: 0,1,2,0,... back to back.
    run_cycles(30, 1'b1);

    // Let held requests finish, then a single directed request from source 1.
    set_probs(0, 0, 0, 100, 100);
    run_cycles(10, 1'b1);
    src_q[1].push_front(make_item(3, 7, 32'hFFFF_0000));
    set_probs(0, 100, 0, 100, 100);
    run_cycles(5, 1'b0);

    // Backpressure from the register file with sources 0 and 2.
    set_probs(100, 0, 100, 30, 100);
    run_cycles(60, 1'b1);

    // Global freeze interleaved with traffic.
    set_probs(70, 70, 70, 70, 60);
    run_cycles(150, 1'b1);

    // Reset while an output is pending.
    set_probs(100, 100, 100, 100, 100);
    mid_reset();
    run_cycles(20, 1'b1);

    // General random mix.
    set_probs(50, 50, 50, 50, 85);
    run_cycles(300, 1'b1);

    // Drain everything still queued.
    set_probs(100, 100, 100, 100, 100);
    budget = 0;
    while (budget < 300 && (m_wbv || exp_q.size() != 0 || cur_valid != '0 ||
           src_q[0].size() != 0 || src_q[1].size() != 0 || src_q[2].size() != 0)) begin
      run_cycles(1, 1'b0);
      budget++;
    end
    check("drain_expected_left", 32'(exp_q.size()), 32'd0);
    check("drain_requests_left", 32'(src_q[0].size() + src_q[1].size() + src_q[2].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
